// File: rtl/alu_instr_sequencer.sv
// Moore control sequencer that fetches an instruction and drives the datapath strobes for ALU ops.
// Optional two-result MUL/DIV support (extra T6 state) is enabled by defining SEQ_MULDIV_EN.
module alu_instr_sequencer #(
  parameter int unsigned NUM_GPR   = 16,
  parameter int unsigned REG_SEL_W = 4,
  parameter int unsigned DATA_W    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic [DATA_W-1:0]    ir,
  input  logic                 mem_ready,
  output logic                 pc_out,
  output logic                 inc_pc,
  output logic                 mar_in,
  output logic                 z_in,
  output logic                 read,
  output logic                 mdr_in,
  output logic                 mdr_out,
  output logic                 ir_in,
  output logic                 y_in,
  output logic                 z_low_out,
  output logic                 z_high_out,
  output logic                 hi_in,
  output logic                 lo_in,
  output logic [NUM_GPR-1:0]   gpr_in,
  output logic [NUM_GPR-1:0]   gpr_out,
  output logic [3:0]           alu_op,
  output logic                 busy,
  output logic                 done,
  output logic                 illegal
);

  localparam int unsigned OP_W   = 5;
  localparam int unsigned OP_LSB = DATA_W - OP_W;
  localparam int unsigned RA_LSB = OP_LSB - REG_SEL_W;
  localparam int unsigned RB_LSB = RA_LSB - REG_SEL_W;
  localparam int unsigned RC_LSB = RB_LSB - REG_SEL_W;
  localparam logic [NUM_GPR-1:0] GPR_ONE = NUM_GPR'(1);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_DONE
`ifdef SEQ_MULDIV_EN
    , S_T6
`endif
  } state_t;

  state_t state;

  logic [OP_W-1:0]      opcode;
  logic [REG_SEL_W-1:0] ra, rb, rc;
  logic [3:0]           alu_op_dec;
  logic                 op_legal, is_muldiv, instr_legal;
  logic                 ra_ok, rb_ok, rc_ok;
  logic                 unused_ir;

  assign opcode    = ir[OP_LSB +: OP_W];
  assign ra        = ir[RA_LSB +: REG_SEL_W];
  assign rb        = ir[RB_LSB +: REG_SEL_W];
  assign rc        = ir[RC_LSB +: REG_SEL_W];
  assign unused_ir = ^ir[RC_LSB-1:0];

  // Field range check is only needed when the register file is smaller than the field can address.
  if (NUM_GPR >= (32'd1 << REG_SEL_W)) begin : g_full_rf
    assign ra_ok = 1'b1;
    assign rb_ok = 1'b1;
    assign rc_ok = 1'b1;
  end else begin : g_part_rf
    assign ra_ok = 32'(ra) < NUM_GPR;
    assign rb_ok = 32'(rb) < NUM_GPR;
    assign rc_ok = 32'(rc) < NUM_GPR;
  end

  always_comb begin : opcode_decode
    op_legal   = 1'b0;
    is_muldiv  = 1'b0;
    alu_op_dec = 4'b0000;
    case (opcode)
      5'b01001: begin op_legal = 1'b1; alu_op_dec = 4'b0000; end
      5'b01010: begin op_legal = 1'b1; alu_op_dec = 4'b0001; end
      5'b00011: begin op_legal = 1'b1; alu_op_dec = 4'b0010; end
      5'b00100: begin op_legal = 1'b1; alu_op_dec = 4'b0011; end
      5'b00101: begin op_legal = 1'b1; alu_op_dec = 4'b0100; end
      5'b00110: begin op_legal = 1'b1; alu_op_dec = 4'b0101; end
      5'b00111: begin op_legal = 1'b1; alu_op_dec = 4'b0110; end
      5'b01000: begin op_legal = 1'b1; alu_op_dec = 4'b0111; end
`ifdef SEQ_MULDIV_EN
      5'b01111: begin op_legal = 1'b1; alu_op_dec = 4'b1000; is_muldiv = 1'b1; end
      5'b10000: begin op_legal = 1'b1; alu_op_dec = 4'b1001; is_muldiv = 1'b1; end
`endif
      default: ;
    endcase
  end

  // MUL/DIV write HI/LO, so the ra field is don't-care for them.
  assign instr_legal = op_legal && rb_ok && rc_ok && (is_muldiv || ra_ok);

  always_ff @(posedge clk) begin : state_reg
    if (reset) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (run) state <= S_T0;
        S_T0:   state <= S_T1;
        S_T1:   if (mem_ready) state <= S_T2;
        S_T2:   state <= S_T3;
        S_T3:   state <= instr_legal ? S_T4 : S_IDLE;
        S_T4:   state <= S_T5;
`ifdef SEQ_MULDIV_EN
        S_T5:   state <= is_muldiv ? S_T6 : S_DONE;
        S_T6:   state <= S_DONE;
`else
        S_T5:   state <= S_DONE;
`endif
        S_DONE: state <= run ? S_T0 : S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Strobes decode from the state register and the IR contents only.
  always_comb begin : strobe_decode
    pc_out     = 1'b0;
    inc_pc     = 1'b0;
    mar_in     = 1'b0;
    z_in       = 1'b0;
    read       = 1'b0;
    mdr_in     = 1'b0;
    mdr_out    = 1'b0;
    ir_in      = 1'b0;
    y_in       = 1'b0;
    z_low_out  = 1'b0;
    z_high_out = 1'b0;
    hi_in      = 1'b0;
    lo_in      = 1'b0;
    gpr_in     = '0;
    gpr_out    = '0;
    alu_op     = 4'b0000;
    done       = 1'b0;
    illegal    = 1'b0;
    busy       = (state != S_IDLE);
    case (state)
      S_T0: begin
        pc_out = 1'b1;
        mar_in = 1'b1;
        inc_pc = 1'b1;
        z_in   = 1'b1;
      end
      S_T1: begin
        read   = 1'b1;
        mdr_in = 1'b1;
      end
      S_T2: begin
        mdr_out = 1'b1;
        ir_in   = 1'b1;
      end
      S_T3: begin
        if (instr_legal) begin
          gpr_out = GPR_ONE << rb;
          y_in    = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      S_T4: begin
        gpr_out = GPR_ONE << rc;
        z_in    = 1'b1;
        alu_op  = alu_op_dec;
      end
      S_T5: begin
        z_low_out = 1'b1;
`ifdef SEQ_MULDIV_EN
        if (is_muldiv) lo_in = 1'b1;
        else           gpr_in = GPR_ONE << ra;
`else
        gpr_in = GPR_ONE << ra;
`endif
      end
`ifdef SEQ_MULDIV_EN
      S_T6: begin
        z_high_out = 1'b1;
        hi_in      = 1'b1;
      end
`endif
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Scoreboard bench for alu_instr_sequencer: 16-register and 8-register instances,
// per-cycle expected strobe traces built from a vector table.
module tb_alu_instr_sequencer;

  logic        clk = 1'b0;
  logic        reset, run16, run8, mem_ready;
  logic [31:0] ir;

  always #5 clk = ~clk;

  logic        a_pc_out, a_inc_pc, a_mar_in, a_z_in, a_read, a_mdr_in, a_mdr_out, a_ir_in;
  logic        a_y_in, a_z_low_out, a_z_high_out, a_hi_in, a_lo_in, a_busy, a_done, a_illegal;
  logic [15:0] a_gpr_in, a_gpr_out;
  logic [3:0]  a_alu_op;

  logic        b_pc_out, b_inc_pc, b_mar_in, b_z_in, b_read, b_mdr_in, b_mdr_out, b_ir_in;
  logic        b_y_in, b_z_low_out, b_z_high_out, b_hi_in, b_lo_in, b_busy, b_done, b_illegal;
  logic [7:0]  b_gpr_in, b_gpr_out;
  logic [3:0]  b_alu_op;

  alu_instr_sequencer #(.NUM_GPR(16), .REG_SEL_W(4), .DATA_W(32)) dut16 (
    .clk(clk), .reset(reset), .run(run16), .ir(ir), .mem_ready(mem_ready),
    .pc_out(a_pc_out), .inc_pc(a_inc_pc), .mar_in(a_mar_in), .z_in(a_z_in),
    .read(a_read), .mdr_in(a_mdr_in), .mdr_out(a_mdr_out), .ir_in(a_ir_in),
    .y_in(a_y_in), .z_low_out(a_z_low_out), .z_high_out(a_z_high_out),
    .hi_in(a_hi_in), .lo_in(a_lo_in), .gpr_in(a_gpr_in), .gpr_out(a_gpr_out),
    .alu_op(a_alu_op), .busy(a_busy), .done(a_done), .illegal(a_illegal)
  );

  alu_instr_sequencer #(.NUM_GPR(8), .REG_SEL_W(4), .DATA_W(32)) dut8 (
    .clk(clk), .reset(reset), .run(run8), .ir(ir), .mem_ready(mem_ready),
    .pc_out(b_pc_out), .inc_pc(b_inc_pc), .mar_in(b_mar_in), .z_in(b_z_in),
    .read(b_read), .mdr_in(b_mdr_in), .mdr_out(b_mdr_out), .ir_in(b_ir_in),
    .y_in(b_y_in), .z_low_out(b_z_low_out), .z_high_out(b_z_high_out),
    .hi_in(b_hi_in), .lo_in(b_lo_in), .gpr_in(b_gpr_in), .gpr_out(b_gpr_out),
    .alu_op(b_alu_op), .busy(b_busy), .done(b_done), .illegal(b_illegal)
  );

  typedef struct packed {
    logic        pc_out, inc_pc, mar_in, z_in, read, mdr_in, mdr_out, ir_in;
    logic        y_in, z_low_out, z_high_out, hi_in, lo_in;
    logic [15:0] gpr_in, gpr_out;
    logic [3:0]  alu_op;
    logic        busy, done, illegal;
  } outs_t;

  typedef struct {
    logic [31:0] ir;
    int          waits;
    bit          legal;
    bit          md;
    logic [3:0]  alu;
    logic [15:0] ra_oh, rb_oh, rc_oh;
    bit          use8;
    string       name;
  } vec_t;

  typedef struct {
    bit    run;
    bit    mem_ready;
    bit    reset;
    bit    use8;
    outs_t exp;
    string name;
  } ent_t;

  vec_t  vecs[$];
  ent_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;
  string cur_name;

  function automatic bit rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic outs_t busy_only();
    outs_t o = '0;
    o.busy = 1'b1;
    return o;
  endfunction

  function automatic outs_t sample(bit use8);
    outs_t o;
    if (use8)
      o = '{b_pc_out, b_inc_pc, b_mar_in, b_z_in, b_read, b_mdr_in, b_mdr_out, b_ir_in,
            b_y_in, b_z_low_out, b_z_high_out, b_hi_in, b_lo_in, 16'(b_gpr_in), 16'(b_gpr_out),
            b_alu_op, b_busy, b_done, b_illegal};
    else
      o = '{a_pc_out, a_inc_pc, a_mar_in, a_z_in, a_read, a_mdr_in, a_mdr_out, a_ir_in,
            a_y_in, a_z_low_out, a_z_high_out, a_hi_in, a_lo_in, a_gpr_in, a_gpr_out,
            a_alu_op, a_busy, a_done, a_illegal};
    return o;
  endfunction

  task automatic add(input logic [31:0] i, input int w, input bit lg, input bit md,
                     input logic [3:0] op, input logic [15:0] ra, input logic [15:0] rb,
                     input logic [15:0] rc, input bit u8, input string nm);
    vec_t v;
    v = '{i, w, lg, md, op, ra, rb, rc, u8, nm};
    vecs.push_back(v);
  endtask

  task automatic push(input string st, input bit u8, input bit r, input bit mr,
                      input bit rst, input outs_t o);
    ent_t e;
    e = '{r, mr, rst, u8, o, {cur_name, ".", st}};
    exp_q.push_back(e);
  endtask

  // Expected per-cycle strobes for one instruction, derived from the state sequence.
  task automatic build_trace(input vec_t v, input bit lead, input bit tail_run, input bit rst_t4);
    outs_t o;
    cur_name = v.name;
    if (lead) push("IDLE", v.use8, 1'b1, rnd(), 1'b0, '0);
    o = busy_only(); o.pc_out = 1; o.mar_in = 1; o.inc_pc = 1; o.z_in = 1;
    push("T0", v.use8, rnd(), rnd(), 1'b0, o);
    for (int i = 0; i <= v.waits; i++) begin
      o = busy_only(); o.read = 1; o.mdr_in = 1;
      push("T1", v.use8, rnd(), i == v.waits, 1'b0, o);
    end
    o = busy_only(); o.mdr_out = 1; o.ir_in = 1;
    push("T2", v.use8, rnd(), rnd(), 1'b0, o);
    o = busy_only();
    if (!v.legal) begin
      o.illegal = 1;
      push("T3", v.use8, rnd(), rnd(), 1'b0, o);
      push("IDLE_AFTER_ILLEGAL", v.use8, 1'b0, rnd(), 1'b0, '0);
      return;
    end
    o.gpr_out = v.rb_oh; o.y_in = 1;
    push("T3", v.use8, rnd(), rnd(), 1'b0, o);
    o = busy_only(); o.gpr_out = v.rc_oh; o.z_in = 1; o.alu_op = v.alu;
    if (rst_t4) begin
      push("T4", v.use8, rnd(), rnd(), 1'b1, o);
      push("AFTER_RESET", v.use8, 1'b0, rnd(), 1'b0, '0);
      push("IDLE", v.use8, 1'b0, rnd(), 1'b0, '0);
      return;
    end
    push("T4", v.use8, rnd(), rnd(), 1'b0, o);
    o = busy_only(); o.z_low_out = 1;
    if (v.md) o.lo_in = 1;
    else      o.gpr_in = v.ra_oh;
    push("T5", v.use8, rnd(), rnd(), 1'b0, o);
    if (v.md) begin
      o = busy_only(); o.z_high_out = 1; o.hi_in = 1;
      push("T6", v.use8, rnd(), rnd(), 1'b0, o);
    end
    o = busy_only(); o.done = 1;
    push("DONE", v.use8, tail_run, rnd(), 1'b0, o);
    if (!tail_run) push("IDLE", v.use8, 1'b0, rnd(), 1'b0, '0);
  endtask

  // Pop one expectation per cycle, compare on the falling edge, then drive the next inputs.
  task automatic drain();
    ent_t  e;
    outs_t got;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e   = exp_q.pop_front();
      got = sample(e.use8);
      checks++;
      if (got !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
      end
      reset     = e.reset;
      mem_ready = e.mem_ready;
      run16     = e.use8 ? 1'b0 : e.run;
      run8      = e.use8 ? e.run : 1'b0;
    end
  endtask

  initial begin
    bit md_en;
`ifdef SEQ_MULDIV_EN
    md_en = 1'b1;
`else
    md_en = 1'b0;
`endif
    reset = 1'b1; run16 = 1'b0; run8 = 1'b0; mem_ready = 1'b0; ir = '0;

    add(32'h4A920000, 0, 1, 0, 4'b0000, 16'h0020, 16'h0004, 16'h0010, 0, "and");
    add(32'h4A920000, 3, 1, 0, 4'b0000, 16'h0020, 16'h0004, 16'h0010, 0, "and_wait3");
    add({5'b00011, 4'd1, 4'd2, 4'd3, 15'd0}, 0, 1, 0, 4'b0010, 16'h0002, 16'h0004, 16'h0008, 0, "add");
    add({5'b00100, 4'd15, 4'd0, 4'd7, 15'd0}, 2, 1, 0, 4'b0011, 16'h8000, 16'h0001, 16'h0080, 0, "sub");
    add({5'b00101, 4'd3, 4'd14, 4'd9, 15'd0}, 0, 1, 0, 4'b0100, 16'h0008, 16'h4000, 16'h0200, 0, "shr");
    add({5'b00110, 4'd6, 4'd6, 4'd6, 15'd0}, 1, 1, 0, 4'b0101, 16'h0040, 16'h0040, 16'h0040, 0, "shl");
    add({5'b00111, 4'd10, 4'd11, 4'd12, 15'd0}, 0, 1, 0, 4'b0110, 16'h0400, 16'h0800, 16'h1000, 0, "ror");
    add({5'b01000, 4'd0, 4'd1, 4'd2, 15'd0}, 0, 1, 0, 4'b0111, 16'h0001, 16'h0002, 16'h0004, 0, "rol");
    add({5'b01010, 4'd13, 4'd4, 4'd5, 15'd0}, 0, 1, 0, 4'b0001, 16'h2000, 16'h0010, 16'h0020, 0, "or");
    add(32'hF8000000, 0, 0, 0, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 0, "illegal_f8");
    add(32'h00000000, 1, 0, 0, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 0, "illegal_zero");
    add(32'h7A920000, 0, md_en, md_en, 4'b1000, 16'h0000, 16'h0004, 16'h0010, 0, "mul");
    add({5'b10000, 4'd0, 4'd3, 4'd1, 15'd0}, 2, md_en, md_en, 4'b1001, 16'h0000, 16'h0008, 16'h0002, 0, "div");
    add(32'h4C920000, 0, 0, 0, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 1, "rf8_ra9");
    add(32'h4A920000, 0, 1, 0, 4'b0000, 16'h0020, 16'h0004, 16'h0010, 1, "rf8_and");
    add({5'b01001, 4'd1, 4'd2, 4'd8, 15'd0}, 0, 0, 0, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 1, "rf8_rc8");
    add({5'b01111, 4'd9, 4'd1, 4'd2, 15'd0}, 0, md_en, md_en, 4'b1000, 16'h0000, 16'h0002, 16'h0004, 1, "rf8_mul_ra9");
    add(32'h4C920000, 0, 1, 0, 4'b0000, 16'h0200, 16'h0004, 16'h0010, 0, "rf16_ra9");

    repeat (3) @(posedge clk);
    cur_name = "reset";
    push("RF16", 1'b0, 1'b0, 1'b0, 1'b1, '0);
    push("RF8", 1'b1, 1'b0, 1'b0, 1'b1, '0);
    push("RELEASED", 1'b0, 1'b0, 1'b1, 1'b0, '0);
    drain();

    foreach (vecs[k]) begin
      ir = vecs[k].ir;
      build_trace(vecs[k], 1'b1, 1'b0, 1'b0);
      drain();
    end

    ir = vecs[0].ir;
    vecs[0].name = "b2b_first";
    build_trace(vecs[0], 1'b1, 1'b1, 1'b0);
    vecs[0].name = "b2b_second";
    build_trace(vecs[0], 1'b0, 1'b0, 1'b0);
    drain();

    vecs[1].name = "reset_in_t4";
    ir = vecs[1].ir;
    build_trace(vecs[1], 1'b1, 1'b0, 1'b1);
    drain();

    ir = vecs[0].ir;
    vecs[0].name = "after_reset";
    build_trace(vecs[0], 1'b1, 1'b0, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
